// File: rtl/esp32_boot_pkg.sv
// ---------------------------------------------------------------------------
// esp32_boot_pkg
//   Shared definitions for the ESP32 boot sequencer:
//   - boot_state_e : 3-bit FSM state encoding, also exported on state_o
//   - en_req_f     : esptool auto-reset decode of DTR/RTS into the EN request
//   - gpio0_req_f  : esptool auto-reset decode of DTR/RTS into the GPIO0 strap
// ---------------------------------------------------------------------------
package esp32_boot_pkg;

    localparam int unsigned StateW = 3;

    typedef enum logic [StateW-1:0] {
        S_PWRUP = 3'd0,
        S_RUN   = 3'd1,
        S_RESET = 3'd2,
        S_BOOT  = 3'd3
    } boot_state_e;

    // Both inputs are the active-low FTDI lines after synchronization.
    function automatic logic en_req_f(input logic ndtr, input logic nrts);
        return nrts | ~ndtr;
    endfunction

    function automatic logic gpio0_req_f(input logic ndtr, input logic nrts);
        return ndtr | ~nrts;
    endfunction

endpackage

// File: rtl/esp32_sync2.sv
// ---------------------------------------------------------------------------
// esp32_sync2
//   Two-flop synchronizer for one asynchronous input.
//   Ports:
//     clk_i   in  1  destination clock
//     reset_i in  1  synchronous active-high reset (both flops load ResetVal)
//     d_i     in  1  asynchronous input
//     q_o     out 1  synchronized output
// ---------------------------------------------------------------------------
module esp32_sync2 #(
    parameter logic ResetVal = 1'b1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], d_i};
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q <= {2{ResetVal}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/esp32_boot_sequencer.sv
// ---------------------------------------------------------------------------
// esp32_boot_sequencer
//   Sequences ESP32 reset and boot-mode entry for the ESP32 passthru path.
//   Decodes esptool DTR/RTS auto-reset into EN/GPIO0 levels, holds EN low
//   after power-up, grants the passthru the SD/GPIO2,4,12,13 lines while the
//   ESP32 is in its bootloader, and issues a sticky programn request when
//   BTN0 is held long enough.
//
//   Ports:
//     clk_25mhz    in   1  system clock
//     reset        in   1  synchronous active-high reset
//     ftdi_ndtr    in   1  async FTDI DTR (active low)
//     ftdi_nrts    in   1  async FTDI RTS (active low)
//     ftdi_txd     in   1  async host->ESP32 UART (only with ESP32_TXD_REARM_EN)
//     btn0_n       in   1  async BTN0 (0 = pressed)
//     en_out       out  1  1 = release ESP32 EN, 0 = hold in reset
//     gpio0_out    out  1  ESP32 GPIO0 strap level
//     sd_own       out  1  1 = passthru owns SD/GPIO2,4,12,13 lines
//     programn_out out  1  0 = request FPGA reconfig (sticky until reset)
//     state_o      out  3  current FSM state
//
//   Build option:
//     ESP32_TXD_REARM_EN  when defined, every synchronized ftdi_txd edge in
//                         S_BOOT restarts the SD release timeout.
//
//   Timers fire on the clock edge at which the counter's MSB first becomes
//   set, i.e. exactly 2^n clocks after the counter was cleared.
// ---------------------------------------------------------------------------
module esp32_boot_sequencer
    import esp32_boot_pkg::*;
#(
    parameter int unsigned C_progndelay           = 16,
    parameter int unsigned C_powerup_en_time      = 0,
    parameter int unsigned C_prog_release_timeout = 26
) (
    input  logic              clk_25mhz,
    input  logic              reset,
    input  logic              ftdi_ndtr,
    input  logic              ftdi_nrts,
    input  logic              ftdi_txd,
    input  logic              btn0_n,
    output logic              en_out,
    output logic              gpio0_out,
    output logic              sd_own,
    output logic              programn_out,
    output logic [StateW-1:0] state_o
);

    localparam int unsigned PwrW = C_powerup_en_time + 1;
    localparam int unsigned ToW  = C_prog_release_timeout + 1;
    localparam int unsigned PgW  = C_progndelay + 1;
    localparam boot_state_e InitState = (C_powerup_en_time > 0) ? S_PWRUP : S_RUN;

    // ---------------------------------------------------------------------
    // Input synchronizers (idle level of every input is 1)
    // ---------------------------------------------------------------------
    logic ndtr_s;
    logic nrts_s;
    logic btn0_n_s;
    logic txd_s;

    esp32_sync2 #(.ResetVal(1'b1)) u_sync_ndtr (
        .clk_i   (clk_25mhz),
        .reset_i (reset),
        .d_i     (ftdi_ndtr),
        .q_o     (ndtr_s)
    );

    esp32_sync2 #(.ResetVal(1'b1)) u_sync_nrts (
        .clk_i   (clk_25mhz),
        .reset_i (reset),
        .d_i     (ftdi_nrts),
        .q_o     (nrts_s)
    );

    esp32_sync2 #(.ResetVal(1'b1)) u_sync_btn0 (
        .clk_i   (clk_25mhz),
        .reset_i (reset),
        .d_i     (btn0_n),
        .q_o     (btn0_n_s)
    );

    esp32_sync2 #(.ResetVal(1'b1)) u_sync_txd (
        .clk_i   (clk_25mhz),
        .reset_i (reset),
        .d_i     (ftdi_txd),
        .q_o     (txd_s)
    );

    logic en_req;
    logic gpio0_req;

    assign en_req    = en_req_f(ndtr_s, nrts_s);
    assign gpio0_req = gpio0_req_f(ndtr_s, nrts_s);

    // ---------------------------------------------------------------------
    // Host UART activity detect
    // ---------------------------------------------------------------------
    logic txd_edge;

`ifdef ESP32_TXD_REARM_EN
    logic txd_prev_q;
    logic txd_prev_d;

    always_comb begin
        txd_prev_d = txd_s;
    end

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            txd_prev_q <= 1'b1;
        end else begin
            txd_prev_q <= txd_prev_d;
        end
    end

    assign txd_edge = txd_s ^ txd_prev_q;
`else
    logic unused_txd;

    assign unused_txd = txd_s;
    assign txd_edge   = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // State, counters and registered outputs
    // ---------------------------------------------------------------------
    boot_state_e state_q, state_d;
    logic [PwrW-1:0] pwr_cnt_q, pwr_cnt_d;
    logic [ToW-1:0]  to_cnt_q, to_cnt_d;
    logic [PgW-1:0]  pg_cnt_q, pg_cnt_d;
    logic            en_out_q, en_out_d;
    logic            gpio0_out_q, gpio0_out_d;
    logic            sd_own_q, sd_own_d;
    logic            programn_q, programn_d;

    // Next state. Counters default to zero so every state entry clears them.
    always_comb begin
        state_d   = state_q;
        pwr_cnt_d = '0;
        to_cnt_d  = '0;

        case (state_q)
            S_PWRUP: begin
                pwr_cnt_d = pwr_cnt_q + PwrW'(1);
                if (pwr_cnt_d[PwrW-1]) begin
                    state_d   = S_RUN;
                    pwr_cnt_d = '0;
                end
            end
            S_RUN: begin
                if (!en_req) begin
                    state_d = S_RESET;
                end
            end
            S_RESET: begin
                if (en_req) begin
                    state_d = gpio0_req ? S_RUN : S_BOOT;
                end
            end
            S_BOOT: begin
                to_cnt_d = txd_edge ? '0 : to_cnt_q + ToW'(1);
                // A new reset request beats a timeout landing in the same cycle.
                if (!en_req) begin
                    state_d  = S_RESET;
                    to_cnt_d = '0;
                end else if (to_cnt_d[ToW-1]) begin
                    state_d  = S_RUN;
                    to_cnt_d = '0;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // Outputs are decoded from the next state so they update on the same
    // edge as the state register (2 sync + 1 register latency).
    always_comb begin
        en_out_d    = 1'b0;
        gpio0_out_d = 1'b1;
        sd_own_d    = 1'b0;

        case (state_d)
            S_PWRUP: begin
                en_out_d = 1'b0;
            end
            S_RUN: begin
                en_out_d = 1'b1;
            end
            S_RESET: begin
                en_out_d    = 1'b0;
                gpio0_out_d = gpio0_req;
            end
            S_BOOT: begin
                en_out_d    = 1'b1;
                gpio0_out_d = gpio0_req;
                sd_own_d    = 1'b1;
            end
            default: begin
                en_out_d = 1'b0;
            end
        endcase
    end

    // BTN0 hold timer; once programn fires the counter freezes until reset.
    always_comb begin
        pg_cnt_d   = pg_cnt_q;
        programn_d = programn_q;

        if (programn_q) begin
            if (!btn0_n_s) begin
                pg_cnt_d = pg_cnt_q + PgW'(1);
                if (pg_cnt_d[PgW-1]) begin
                    programn_d = 1'b0;
                end
            end else begin
                pg_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            state_q     <= InitState;
            pwr_cnt_q   <= '0;
            to_cnt_q    <= '0;
            pg_cnt_q    <= '0;
            en_out_q    <= 1'b0;
            gpio0_out_q <= 1'b1;
            sd_own_q    <= 1'b0;
            programn_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            pwr_cnt_q   <= pwr_cnt_d;
            to_cnt_q    <= to_cnt_d;
            pg_cnt_q    <= pg_cnt_d;
            en_out_q    <= en_out_d;
            gpio0_out_q <= gpio0_out_d;
            sd_own_q    <= sd_own_d;
            programn_q  <= programn_d;
        end
    end

    assign en_out       = en_out_q;
    assign gpio0_out    = gpio0_out_q;
    assign sd_own       = sd_own_q;
    assign programn_out = programn_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_esp32_boot_sequencer.sv
// ---------------------------------------------------------------------------
// tb_esp32_boot_sequencer
//   Directed scenarios plus randomized stimulus, every cycle compared against
//   a timeline model: inputs take effect two edges after they are sampled,
//   and timers are expressed as "edges since an event".
// ---------------------------------------------------------------------------
module tb_esp32_boot_sequencer;

    localparam int unsigned PwrupClks   = 16;  // 2^4
    localparam int unsigned ReleaseClks = 64;  // 2^6
    localparam int unsigned ProgClks    = 8;   // 2^3

`ifdef ESP32_TXD_REARM_EN
    localparam bit Rearm = 1'b1;
`else
    localparam bit Rearm = 1'b0;
`endif

    localparam int StPwrup = 0;
    localparam int StRun   = 1;
    localparam int StReset = 2;
    localparam int StBoot  = 3;

    logic       clk;
    logic       rst;
    logic       ndtr;
    logic       nrts;
    logic       txd;
    logic       btn;
    logic       en_out;
    logic       gpio0_out;
    logic       sd_own;
    logic       programn_out;
    logic [2:0] state_o;

    esp32_boot_sequencer #(
        .C_progndelay           (3),
        .C_powerup_en_time      (4),
        .C_prog_release_timeout (6)
    ) dut (
        .clk_25mhz    (clk),
        .reset        (rst),
        .ftdi_ndtr    (ndtr),
        .ftdi_nrts    (nrts),
        .ftdi_txd     (txd),
        .btn0_n       (btn),
        .en_out       (en_out),
        .gpio0_out    (gpio0_out),
        .sd_own       (sd_own),
        .programn_out (programn_out),
        .state_o      (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Model state
    logic [3:0] dq[$];       // {txd, btn, nrts, ndtr} in flight through the synchronizers
    int         m_state;
    int         m_cyc;       // edges since reset released
    int         m_tref;      // edge of boot entry or last UART activity
    int         m_press;     // consecutive pressed edges
    bit         m_pn;
    bit         m_prev_txd;
    bit         m_en;
    bit         m_g;
    bit         m_sd;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", tag, m_cyc, got, exp);
        end
    endtask

    task automatic model_edge();
        logic [3:0] eff;
        bit ereq;
        bit greq;
        bit txe;
        if (rst) begin
            dq.delete();
            dq.push_back(4'hF);
            dq.push_back(4'hF);
            m_state    = StPwrup;
            m_cyc      = 0;
            m_tref     = 0;
            m_press    = 0;
            m_pn       = 1'b1;
            m_prev_txd = 1'b1;
            m_en       = 1'b0;
            m_g        = 1'b1;
            m_sd       = 1'b0;
            return;
        end
        m_cyc++;
        eff = dq.pop_front();
        dq.push_back({txd, btn, nrts, ndtr});
        ereq = eff[1] | ~eff[0];
        greq = eff[0] | ~eff[1];
        txe  = Rearm && (eff[3] != m_prev_txd);
        m_prev_txd = eff[3];

        case (m_state)
            StPwrup: if (m_cyc == PwrupClks) m_state = StRun;
            StRun:   if (!ereq) m_state = StReset;
            StReset: if (ereq) begin
                m_state = greq ? StRun : StBoot;
                m_tref  = m_cyc;
            end
            default: begin
                if (!ereq) m_state = StReset;
                else if (txe) m_tref = m_cyc;
                else if (m_cyc - m_tref == ReleaseClks) m_state = StRun;
            end
        endcase

        if (m_pn) begin
            if (!eff[2]) begin
                m_press++;
                if (m_press == ProgClks) m_pn = 1'b0;
            end else begin
                m_press = 0;
            end
        end

        m_en = (m_state == StRun) || (m_state == StBoot);
        m_g  = (m_state == StReset || m_state == StBoot) ? greq : 1'b1;
        m_sd = (m_state == StBoot);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            model_edge();
            check("en_out", {7'd0, en_out}, {7'd0, m_en});
            check("gpio0_out", {7'd0, gpio0_out}, {7'd0, m_g});
            check("sd_own", {7'd0, sd_own}, {7'd0, m_sd});
            check("programn_out", {7'd0, programn_out}, {7'd0, m_pn});
            check("state_o", {5'd0, state_o}, m_state[7:0]);
        end
    endtask

    task automatic set_lines(input logic dtr_n, input logic rts_n);
        ndtr = dtr_n;
        nrts = rts_n;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        step(n);
        rst = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        ndtr  = 1'b1;
        nrts  = 1'b1;
        txd   = 1'b1;
        btn   = 1'b1;

        // 1. reset state, power-up hold, idle release
        do_reset(3);
        step(PwrupClks - 1);
        check("t1_en_held", {7'd0, en_out}, 8'd0);
        step(5);
        check("t1_state_run", {5'd0, state_o}, 8'd1);
        check("t1_en_released", {7'd0, en_out}, 8'd1);

        // 2. reset pulse then boot entry, timeout release
        set_lines(1'b1, 1'b0);
        step(10);
        set_lines(1'b0, 1'b1);
        step(5);
        check("t2_boot_state", {5'd0, state_o}, 8'd3);
        check("t2_boot_gpio0", {7'd0, gpio0_out}, 8'd0);
        step(80);
        check("t2_released", {7'd0, sd_own}, 8'd0);
        set_lines(1'b1, 1'b1);
        step(5);

        // 3. reset request racing the timeout
        for (int off = 58; off <= 63; off++) begin
            set_lines(1'b1, 1'b0);
            step(6);
            set_lines(1'b0, 1'b1);
            step(3);
            step(off);
            set_lines(1'b1, 1'b0);
            step(8);
            set_lines(1'b1, 1'b1);
            step(6);
        end

        // 4. plain reset, no boot
        set_lines(1'b1, 1'b0);
        step(6);
        set_lines(1'b1, 1'b1);
        step(8);
        check("t4_no_boot", {5'd0, state_o}, 8'd1);

        // 5. BTN0 short and long presses
        btn = 1'b0;
        step(7);
        btn = 1'b1;
        step(6);
        check("t5_short_press", {7'd0, programn_out}, 8'd1);
        btn = 1'b0;
        step(9);
        btn = 1'b1;
        step(10);
        check("t5_long_press", {7'd0, programn_out}, 8'd0);
        do_reset(2);
        step(PwrupClks + 2);

        // 6. UART activity during boot
        set_lines(1'b1, 1'b0);
        step(6);
        set_lines(1'b0, 1'b1);
        step(3);
        for (int k = 0; k < 5; k++) begin
            txd = ~txd;
            step(40);
        end
        step(80);
        set_lines(1'b1, 1'b1);
        step(6);

        // Mid-operation reset during boot
        set_lines(1'b1, 1'b0);
        step(6);
        set_lines(1'b0, 1'b1);
        btn = 1'b0;
        step(6);
        do_reset(1);
        set_lines(1'b1, 1'b1);
        btn = 1'b1;
        step(PwrupClks + 4);

        // Randomized stimulus
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 15) == 0) ndtr = ~ndtr;
            if ($urandom_range(0, 15) == 0) nrts = ~nrts;
            if ($urandom_range(0, 19) == 0) btn = ~btn;
            if ($urandom_range(0, 29) == 0) txd = ~txd;
            if ($urandom_range(0, 599) == 0) begin
                do_reset(1);
            end else begin
                step(1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
